// File: rtl/ddr3_dqs_eye_tracker.sv
// ddr3_dqs_eye_tracker
//   Closed-loop read-strobe centring for one DDR3 DQS/DQ lane IOD. Repeatedly
//   clears the IOD eye-monitor flags, lets them settle, votes early/late over a
//   window and nudges the IOD delay line one tap toward the eye centre.
//
// Ports
//   FAB_CLK                  lane fabric clock
//   RX_SYNC_RST              synchronous reset, active-high
//   EN                       tracking enable (level)
//   LOAD_REQ                 pulse: reload static delay, preset tap counter
//   INIT_TAP[7:0]            tap matching the IOD static delay, taken on LOAD_REQ
//   EYE_MONITOR_EARLY/LATE   eye-monitor flags from the IOD
//   DELAY_LINE_OUT_OF_RANGE  delay-line range flag from the IOD
//   EYE_MONITOR_CLEAR_FLAGS  pulse to the IOD: clear the eye-monitor flags
//   DELAY_LINE_MOVE          pulse to the IOD: step the delay line one tap
//   DELAY_LINE_DIRECTION     1 = increase delay; meaningful with MOVE
//   DELAY_LINE_LOAD          pulse to the IOD: reload the static delay
//   TAP[7:0]                 current tap estimate
//   LOCKED                   eye is centred
//   ERR                      sticky range error
//
// Build option
//   DQS_TRACK_HYST_EN        when defined, a move needs two consecutive
//                            decisions in the same direction.

module ddr3_dqs_eye_tracker #(
  parameter int unsigned TAP_MAX    = 127,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned VOTE_N     = 4,
  parameter int unsigned LOCK_CNT   = 3
) (
  input  logic       FAB_CLK,
  input  logic       RX_SYNC_RST,
  input  logic       EN,
  input  logic       LOAD_REQ,
  input  logic [7:0] INIT_TAP,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  output logic [7:0] TAP,
  output logic       LOCKED,
  output logic       ERR
);

  localparam int unsigned TW = 8;   // tap width
  localparam int unsigned CW = 4;   // vote / stable counter width
  localparam int unsigned SW = 8;   // settle counter width

  localparam logic [TW-1:0] TAP_TOP     = TW'(TAP_MAX);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] VOTE_LAST   = CW'(VOTE_N - 1);
  localparam logic [CW-1:0] LOCK_TOP    = CW'(LOCK_CNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_DECIDE,
    S_MOVE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tap_q, tap_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic [CW-1:0]   stable_q, stable_d;
  logic [CW-1:0]   early_q, early_d;
  logic [CW-1:0]   late_q, late_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [CW-1:0]   vote_q, vote_d;
  logic            clr_q, clr_d;
  logic            move_q, move_d;
  logic            dir_q, dir_d;
  logic            load_q, load_d;
  logic            pend_q, pend_d;      // LOAD_REQ seen outside IDLE
  logic [TW-1:0]   init_q, init_d;      // INIT_TAP captured with it
  logic            chk_q, chk_d;        // cycle after a MOVE pulse
  logic            blk_vld_q, blk_vld_d;
  logic            blk_dir_q, blk_dir_d;
`ifdef DQS_TRACK_HYST_EN
  logic            hyst_vld_q, hyst_vld_d;
  logic            hyst_dir_q, hyst_dir_d;
`endif

  // Decision helpers
  logic            go_loop;
  logic            do_move;
  logic            req_inc;
  logic            req_dec;
  logic            req_dir;
  logic            at_limit;
  logic [CW-1:0]   stable_nxt;
  logic [TW-1:0]   load_val;

  assign TAP                     = tap_q;
  assign LOCKED                  = locked_q;
  assign ERR                     = err_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign DELAY_LINE_LOAD         = load_q;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    locked_d   = locked_q;
    err_d      = err_q;
    stable_d   = stable_q;
    early_d    = early_q;
    late_d     = late_q;
    settle_d   = settle_q;
    vote_d     = vote_q;
    clr_d      = 1'b0;
    move_d     = 1'b0;
    dir_d      = dir_q;
    load_d     = 1'b0;
    pend_d     = pend_q;
    init_d     = init_q;
    chk_d      = 1'b0;
    blk_vld_d  = blk_vld_q;
    blk_dir_d  = blk_dir_q;
`ifdef DQS_TRACK_HYST_EN
    hyst_vld_d = hyst_vld_q;
    hyst_dir_d = hyst_dir_q;
`endif
    go_loop    = 1'b0;
    do_move    = 1'b0;
    req_inc    = (early_q > late_q);
    req_dec    = (late_q > early_q);
    req_dir    = req_inc;
    at_limit   = req_inc ? (tap_q == TAP_TOP) : (tap_q == '0);
    stable_nxt = (stable_q == LOCK_TOP) ? stable_q : (stable_q + CW'(1));
    load_val   = LOAD_REQ ? INIT_TAP : init_q;

    // Load requests arriving mid-loop wait for the next IDLE
    if (LOAD_REQ && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
      init_d = INIT_TAP;
    end

    // IOD rejected the last step: undo it and fence off that direction
    if (chk_q && DELAY_LINE_OUT_OF_RANGE) begin
      err_d     = 1'b1;
      tap_d     = dir_q ? (tap_q - TW'(1)) : (tap_q + TW'(1));
      blk_vld_d = 1'b1;
      blk_dir_d = dir_q;
    end

    case (state_q)
      S_IDLE: begin
        if (LOAD_REQ || pend_q) begin
          state_d   = S_LOAD;
          load_d    = 1'b1;
          tap_d     = (load_val > TAP_TOP) ? TAP_TOP : load_val;
          locked_d  = 1'b0;
          err_d     = 1'b0;
          stable_d  = '0;
          pend_d    = 1'b0;
          blk_vld_d = 1'b0;
`ifdef DQS_TRACK_HYST_EN
          hyst_vld_d = 1'b0;
`endif
        end else if (EN) begin
          go_loop = 1'b1;
        end
      end

      S_LOAD: state_d = S_IDLE;

      S_CLEAR: begin
        state_d  = S_SETTLE;
        settle_d = '0;
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
          vote_d  = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      S_SAMPLE: begin
        early_d = early_q + CW'(EYE_MONITOR_EARLY);
        late_d  = late_q + CW'(EYE_MONITOR_LATE);
        if (vote_q == VOTE_LAST) begin
          state_d = S_DECIDE;
        end else begin
          vote_d = vote_q + CW'(1);
        end
      end

      S_DECIDE: begin
        if (!req_inc && !req_dec) begin
          stable_d = stable_nxt;
          if (stable_nxt == LOCK_TOP) locked_d = 1'b1;
`ifdef DQS_TRACK_HYST_EN
          hyst_vld_d = 1'b0;
`endif
          go_loop = 1'b1;
        end else begin
          stable_d = '0;
          // A request in the opposite direction lifts the fence
          if (blk_vld_q && (blk_dir_q != req_dir)) blk_vld_d = 1'b0;
          if (at_limit) begin
            err_d = 1'b1;
`ifdef DQS_TRACK_HYST_EN
            hyst_vld_d = 1'b0;
`endif
            go_loop = 1'b1;
          end else if (blk_vld_q && (blk_dir_q == req_dir)) begin
`ifdef DQS_TRACK_HYST_EN
            hyst_vld_d = 1'b0;
`endif
            go_loop = 1'b1;
          end else begin
`ifdef DQS_TRACK_HYST_EN
            if (hyst_vld_q && (hyst_dir_q == req_dir)) begin
              do_move    = 1'b1;
              hyst_vld_d = 1'b0;
            end else begin
              hyst_vld_d = 1'b1;
              hyst_dir_d = req_dir;
              go_loop    = 1'b1;
            end
`else
            do_move = 1'b1;
`endif
          end
        end
        if (do_move) begin
          state_d  = S_MOVE;
          move_d   = 1'b1;
          dir_d    = req_dir;
          tap_d    = req_dir ? (tap_q + TW'(1)) : (tap_q - TW'(1));
          locked_d = 1'b0;
        end
      end

      S_MOVE: begin
        chk_d   = 1'b1;
        go_loop = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Start another decision loop, or park in IDLE once tracking is disabled
    if (go_loop) begin
      if (EN) begin
        state_d = S_CLEAR;
        clr_d   = 1'b1;
        early_d = '0;
        late_d  = '0;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State and output registers
  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state_q    <= S_IDLE;
      tap_q      <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      stable_q   <= '0;
      early_q    <= '0;
      late_q     <= '0;
      settle_q   <= '0;
      vote_q     <= '0;
      clr_q      <= 1'b0;
      move_q     <= 1'b0;
      dir_q      <= 1'b0;
      load_q     <= 1'b0;
      pend_q     <= 1'b0;
      init_q     <= '0;
      chk_q      <= 1'b0;
      blk_vld_q  <= 1'b0;
      blk_dir_q  <= 1'b0;
`ifdef DQS_TRACK_HYST_EN
      hyst_vld_q <= 1'b0;
      hyst_dir_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      stable_q   <= stable_d;
      early_q    <= early_d;
      late_q     <= late_d;
      settle_q   <= settle_d;
      vote_q     <= vote_d;
      clr_q      <= clr_d;
      move_q     <= move_d;
      dir_q      <= dir_d;
      load_q     <= load_d;
      pend_q     <= pend_d;
      init_q     <= init_d;
      chk_q      <= chk_d;
      blk_vld_q  <= blk_vld_d;
      blk_dir_q  <= blk_dir_d;
`ifdef DQS_TRACK_HYST_EN
      hyst_vld_q <= hyst_vld_d;
      hyst_dir_q <= hyst_dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddr3_dqs_eye_tracker.sv
// Testbench for ddr3_dqs_eye_tracker: directed stimulus; expected MOVE and
// LOAD pulses are queued by the stimulus and checked by a negedge monitor.
module tb_ddr3_dqs_eye_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load_req;
  logic [7:0] init_tap;
  logic       early;
  logic       late;
  logic       oor;
  logic       clr_flags;
  logic       mv;
  logic       dir;
  logic       ld;
  logic [7:0] tap;
  logic       locked;
  logic       err;

  always #5 clk = ~clk;

  ddr3_dqs_eye_tracker dut (
    .FAB_CLK                 (clk),
    .RX_SYNC_RST             (rst),
    .EN                      (en),
    .LOAD_REQ                (load_req),
    .INIT_TAP                (init_tap),
    .EYE_MONITOR_EARLY       (early),
    .EYE_MONITOR_LATE        (late),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .EYE_MONITOR_CLEAR_FLAGS (clr_flags),
    .DELAY_LINE_MOVE         (mv),
    .DELAY_LINE_DIRECTION    (dir),
    .DELAY_LINE_LOAD         (ld),
    .TAP                     (tap),
    .LOCKED                  (locked),
    .ERR                     (err)
  );

  typedef struct packed {
    logic       dir;
    logic [7:0] tap;
  } move_exp_t;

  move_exp_t  move_q[$];
  logic [7:0] load_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue LOAD_REQ and expect the LOAD pulse on the next cycle
  task automatic do_load(input logic [7:0] v, input logic [7:0] exp_tap);
    load_q.push_back(exp_tap);
    init_tap = v;
    load_req = 1'b1;
    tick();
    check("load_latency", int'(ld), 1);
    load_req = 1'b0;
    tick();
  endtask

  // Advance until a MOVE pulse appears or the budget runs out
  task automatic wait_move(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!mv && n < budget);
    if (!mv) begin
      checks++;
      failures++;
      $display("FAIL move_timeout: no MOVE within %0d cycles", budget);
    end
  endtask

  // Monitor: every MOVE/LOAD pulse must match the head of its queue
  initial begin : monitor
    logic      prev_mv;
    logic      prev_ld;
    logic      prev_clr;
    move_exp_t me;
    logic [7:0] le;
    prev_mv  = 1'b0;
    prev_ld  = 1'b0;
    prev_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (mv) begin
        check("move_width", int'(prev_mv), 0);
        checks++;
        if (move_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_move: dir=%0d tap=%0d none expected", dir, tap);
        end else begin
          me = move_q.pop_front();
          check("move_dir", int'(dir), int'(me.dir));
          check("move_tap", int'(tap), int'(me.tap));
        end
      end
      if (ld) begin
        check("load_width", int'(prev_ld), 0);
        checks++;
        if (load_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_load: tap=%0d none expected", tap);
        end else begin
          le = load_q.pop_front();
          check("load_tap", int'(tap), int'(le));
          check("load_locked", int'(locked), 0);
          check("load_err", int'(err), 0);
        end
      end
      if (clr_flags) check("clear_width", int'(prev_clr), 0);
      prev_mv  = mv;
      prev_ld  = ld;
      prev_clr = clr_flags;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst      = 1'b1;
    en       = 1'b0;
    load_req = 1'b0;
    init_tap = 8'd0;
    early    = 1'b0;
    late     = 1'b0;
    oor      = 1'b0;
    repeat (3) tick();
    check("rst_tap", int'(tap), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    check("rst_clr", int'(clr_flags), 0);
    check("rst_move", int'(mv), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_load", int'(ld), 0);
    rst = 1'b0;
    tick();

    // Load 40
    do_load(8'd40, 8'd40);
    check("load40_tap", int'(tap), 40);

    // Increase: three 15-cycle loops from 40
    move_q.push_back('{dir: 1'b1, tap: 8'd41});
    move_q.push_back('{dir: 1'b1, tap: 8'd42});
    move_q.push_back('{dir: 1'b1, tap: 8'd43});
    early = 1'b1;
    en    = 1'b1;
    tick();
    check("clr_latency", int'(clr_flags), 1);
    wait_move(40, n);
    check("first_move_gap", n, 14);
    wait_move(40, n);
    check("move_gap2", n, 15);
    wait_move(40, n);
    check("move_gap3", n, 15);
    en    = 1'b0;
    early = 1'b0;
    tick();
    check("inc_tap", int'(tap), 43);

    // Lock at 50: three neutral 14-cycle loops counted from the first CLEAR
    do_load(8'd50, 8'd50);
    en = 1'b1;
    tick();
    check("lock_clr", int'(clr_flags), 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!locked && n < 60);
    check("lock_delay", n, 42);
    move_q.push_back('{dir: 1'b0, tap: 8'd49});
    late = 1'b1;
    repeat (13) tick();
    check("locked_before_move", int'(locked), 1);
    check("no_move_yet", int'(mv), 0);
    tick();
    check("late_move", int'(mv), 1);
    check("locked_drop", int'(locked), 0);
    check("late_tap", int'(tap), 49);
    en   = 1'b0;
    late = 1'b0;
    tick();

    // Range limit: INIT_TAP above TAP_MAX clamps to 127, then increase blocked
    do_load(8'd200, 8'd127);
    early = 1'b1;
    en    = 1'b1;
    tick();
    repeat (13) tick();
    check("limit_err_before", int'(err), 0);
    tick();
    check("limit_err", int'(err), 1);
    check("limit_tap", int'(tap), 127);
    en    = 1'b0;
    early = 1'b0;
    repeat (16) tick();
    check("limit_tap_hold", int'(tap), 127);
    check("limit_err_hold", int'(err), 1);

    // Out of range after a step up from 10
    do_load(8'd10, 8'd10);
    move_q.push_back('{dir: 1'b1, tap: 8'd11});
    early = 1'b1;
    en    = 1'b1;
    tick();
    wait_move(40, n);
    check("oor_move_gap", n, 14);
    tick();
    oor = 1'b1;
    tick();
    oor = 1'b0;
    check("oor_err", int'(err), 1);
    check("oor_tap_undo", int'(tap), 10);
    repeat (30) tick();
    check("oor_blocked_tap", int'(tap), 10);
    en    = 1'b0;
    early = 1'b0;
    repeat (16) tick();

    // Reset during SAMPLE
    do_load(8'd60, 8'd60);
    early = 1'b1;
    en    = 1'b1;
    tick();
    repeat (10) tick();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    check("mid_rst_tap", int'(tap), 0);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_move", int'(mv), 0);
    check("mid_rst_clr", int'(clr_flags), 0);
    check("mid_rst_dir", int'(dir), 0);
    rst   = 1'b0;
    early = 1'b0;
    repeat (20) tick();
    check("post_rst_tap", int'(tap), 0);

    // One EARLY decision then a neutral one
    do_load(8'd20, 8'd20);
`ifndef DQS_TRACK_HYST_EN
    move_q.push_back('{dir: 1'b1, tap: 8'd21});
`endif
    early = 1'b1;
    en    = 1'b1;
    tick();
    repeat (17) tick();
    early = 1'b0;
    en    = 1'b0;
    repeat (16) tick();
`ifdef DQS_TRACK_HYST_EN
    check("single_vote_tap", int'(tap), 20);
`else
    check("single_vote_tap", int'(tap), 21);
`endif

    // LOAD_REQ mid-loop is held until IDLE, with INIT_TAP taken at the request
    en = 1'b1;
    tick();
    repeat (3) tick();
    load_q.push_back(8'd77);
    init_tap = 8'd77;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    init_tap = 8'd5;
    en       = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ld && n < 40);
    check("pending_load_seen", int'(ld), 1);
    repeat (5) tick();

    check("move_q_empty", move_q.size(), 0);
    check("load_q_empty", load_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
